lobster_hash_cache: RTL and testbench
=====================================

Name: lobster_hash_cache

Overview:
- Parametrised, tagged, direct-mapped hashed cache; next generation of the lobster key/value cache.
- Adds valid bits and full-address tags, so a read reports a hit or a miss.
- Uses a valid/ready request handshake and a registered response.
- Reverse lookup (find) is a sequential one-entry-per-cycle scan rather than a combinational loop.
- Sits between the core's lookup logic and any structure needing a small address->data memo table.

Parameters:
- ADDR_WIDTH, 32, key/address width; legal range 1..64.
- DATA_WIDTH, 32, stored value width; minimum 2.
- INDEX_BITS, 8, log2 of entry count; NUM_ENTRIES = 2**INDEX_BITS; legal range 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  operation: 00 read, 01 write, 10 find, 11 invalidate.
- req_addr  in  ADDR_WIDTH  key for read, write and invalidate.
- req_data  in  DATA_WIDTH  write value, or search value for find.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_hit  out  1  hit / match / entry-was-present flag.
- resp_data  out  DATA_WIDTH  read data, or the index found by find.
- busy  out  1  high in INIT, HASH, LOOKUP and SCAN.

Behaviour:
- Storage, per entry: valid bit, tag (ADDR_WIDTH), data (DATA_WIDTH).
- Hash fold: f = addr[31:0] XOR (addr >> 32), truncated to 32 bits.
- Hash, all products mod 2^32:
  - h1 = ((f>>16)^f)*32'h45d9f3b
  - h2 = ((h1>>16)^h1)*32'h45d9f3b
  - h = (h2>>16)^h2
  - idx = h[INDEX_BITS-1:0]
- Reset, any cycle including mid-operation:
  - state goes to INIT; sweep counter = 0.
  - req_ready=0, resp_valid=0, resp_hit=0, resp_data=0, busy=1.
  - A pending response is dropped.
- FSM states: INIT, IDLE, HASH, LOOKUP, SCAN, RESP.
- INIT:
  - Clears one valid bit per cycle, from index 0 to NUM_ENTRIES-1.
  - Goes to IDLE after the last entry, so it lasts exactly NUM_ENTRIES cycles after rst deasserts.
  - Tag and data contents are not cleared.
- IDLE:
  - req_ready=1 only in this state.
  - On req_valid&&req_ready, latch op/addr/data.
  - Next state is HASH for op 00/01/11, or SCAN for op 10 with scan index 0.
- HASH: register idx (1 cycle), then go to LOOKUP.
- LOOKUP: read the entry at idx; hit = valid && tag==addr. Then act by op:
  - Read: resp_hit=hit; resp_data = hit ? data : 0.
  - Write: entry <= {1, addr, data}; resp_hit = hit, where 1 means same key overwritten and 0 means empty slot or eviction; resp_data = old data if valid, else 0.
  - Invalidate: if hit, clear valid; resp_hit=hit; resp_data=0.
  - Go to RESP.
- Latency for read/write/invalidate: request accepted at cycle 0, resp_valid high at cycle 3.
- SCAN (find):
  - Checks entry i each cycle for valid && data==req_data.
  - First match: resp_hit=1, resp_data = i zero-extended; go to RESP.
  - After entry NUM_ENTRIES-1 with no match: resp_hit=0, resp_data = {1'b1, zeros} (negative); go to RESP.
  - Lowest matching index wins. Worst case is NUM_ENTRIES+1 cycles to response.
- RESP:
  - resp_valid=1; resp_hit and resp_data held stable.
  - On resp_ready, resp_valid drops and state returns to IDLE.
  - A new request cannot be accepted in the same cycle the response is taken; the earliest is the next cycle.
- Simultaneous events:
  - rst low overrides everything.
  - req_valid while not IDLE is ignored and must be held by the requester.
- A write to a slot holding a different tag replaces it; there is no associativity.

Optional Feature:
- Macro LOBSTER_HASH_CACHE_STATS_EN.
- When defined, adds two outputs: stat_hits (out, 32) and stat_misses (out, 32).
- Counting:
  - Read and find responses only; counted on the cycle the response is accepted.
  - stat_hits increments when resp_hit=1; stat_misses increments when resp_hit=0.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Init: release rst after 2 cycles -> busy=1, req_ready=0 for exactly 256 cycles (INDEX_BITS=8), then req_ready=1; read 32'h0 -> resp_hit=0, resp_data=0.
- Write/read: write addr 32'hFFF80000, data 32'h12345678 -> resp_hit=0. Then read 32'hFFF80000 -> resp_hit=1, resp_data=32'h12345678, resp_valid exactly 3 cycles after acceptance.
- Collision: find a second address with the same idx; write it with 32'hCAFEBABE -> resp_hit=0, resp_data=32'h12345678. Read 32'hFFF80000 -> resp_hit=0.
- Find: write 32'hDEADBEEF at address A (idx k) -> find 32'hDEADBEEF returns resp_hit=1, resp_data=k. Find 32'h0BADF00D -> resp_hit=0, resp_data=32'h80000000 after 257 cycles.
- Backpressure/reset: hold resp_ready=0 for 10 cycles -> resp_valid and resp_data stable, req_ready=0. Assert rst low mid-SCAN -> resp_valid=0 next cycle and INIT restarts.
- Stats (macro defined): 3 read hits and 2 read misses -> stat_hits=3, stat_misses=2. Writes and invalidates leave both unchanged.

Source files
------------

// File: rtl/lobster_hash_cache_if.sv
// Request/response bus for lobster_hash_cache: valid/ready request channel and
// a registered response channel held until the consumer accepts it.
interface lobster_hash_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_addr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_data
    );
endinterface

// File: rtl/lobster_hash_cache.sv
// Tagged direct-mapped hashed key/value cache with sequential reverse lookup.
// Optional hit/miss statistics outputs are enabled by LOBSTER_HASH_CACHE_STATS_EN.
module lobster_hash_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    lobster_hash_cache_if.slave bus,
    output logic                busy
`ifdef LOBSTER_HASH_CACHE_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
`endif
);

    localparam int NUM_ENTRIES = 1 << INDEX_BITS;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FIND  = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_HASH,
        S_LOOKUP,
        S_SCAN,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [ADDR_WIDTH-1:0]  r_tag [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  r_mem [NUM_ENTRIES];

    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [INDEX_BITS-1:0] r_idx;
    logic [INDEX_BITS-1:0] r_cnt;
    logic                  r_resp_hit;
    logic [DATA_WIDTH-1:0] r_resp_data;

    logic w_accept;
    logic w_hit;
    logic w_scan_match;
    logic w_cnt_last;

    function automatic logic [INDEX_BITS-1:0] hash_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [63:0] a64;
        logic [31:0] f;
        logic [31:0] h1;
        logic [31:0] h2;
        logic [31:0] h;
        a64 = 64'(addr);
        f   = a64[31:0] ^ a64[63:32];
        h1  = ((f >> 16) ^ f) * 32'h045d9f3b;
        h2  = ((h1 >> 16) ^ h1) * 32'h045d9f3b;
        h   = (h2 >> 16) ^ h2;
        return h[INDEX_BITS-1:0];
    endfunction

    assign w_accept     = (r_state == S_IDLE) && bus.req_valid;
    assign w_hit        = r_valid[r_idx] && (r_tag[r_idx] == r_addr);
    assign w_scan_match = r_valid[r_cnt] && (r_mem[r_cnt] == r_wdata);
    assign w_cnt_last   = &r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:   if (w_cnt_last) w_state_nxt = S_IDLE;
            S_IDLE:   if (bus.req_valid) w_state_nxt = (bus.req_op == OP_FIND) ? S_SCAN : S_HASH;
            S_HASH:   w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = S_RESP;
            S_SCAN:   if (w_scan_match || w_cnt_last) w_state_nxt = S_RESP;
            S_RESP:   if (bus.resp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_INIT;
        endcase
    end

    // Request latch and hash index register; no reset needed, always written before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_data;
        end
        if (r_state == S_HASH) begin
            r_idx <= hash_idx(r_addr);
        end
    end

    // Entry storage: INIT sweeps valid bits only, tags and data keep stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            case (r_state)
                S_INIT: r_valid[r_cnt] <= 1'b0;
                S_LOOKUP: begin
                    if (r_op == OP_WRITE) begin
                        r_valid[r_idx] <= 1'b1;
                        r_tag[r_idx]   <= r_addr;
                        r_mem[r_idx]   <= r_wdata;
                    end else if ((r_op == OP_INV) && w_hit) begin
                        r_valid[r_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // r_cnt is shared by the INIT sweep and the find scan.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_resp_hit  <= 1'b0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                S_INIT: r_cnt <= r_cnt + 1'b1;
                S_IDLE: if (w_accept) r_cnt <= '0;
                S_LOOKUP: begin
                    r_resp_hit <= w_hit;
                    case (r_op)
                        OP_READ:  r_resp_data <= w_hit ? r_mem[r_idx] : '0;
                        OP_WRITE: r_resp_data <= r_valid[r_idx] ? r_mem[r_idx] : '0;
                        default:  r_resp_data <= '0;
                    endcase
                end
                S_SCAN: begin
                    if (w_scan_match) begin
                        r_resp_hit  <= 1'b1;
                        r_resp_data <= DATA_WIDTH'(r_cnt);
                    end else if (w_cnt_last) begin
                        r_resp_hit  <= 1'b0;
                        r_resp_data <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_hit   = r_resp_hit;
    assign bus.resp_data  = r_resp_data;
    assign busy           = (r_state == S_INIT) || (r_state == S_HASH) ||
                            (r_state == S_LOOKUP) || (r_state == S_SCAN);

`ifdef LOBSTER_HASH_CACHE_STATS_EN
    logic w_stat_evt;
    assign w_stat_evt = (r_state == S_RESP) && bus.resp_ready &&
                        ((r_op == OP_READ) || (r_op == OP_FIND));

    // Saturating counters of read/find outcomes, sampled as the response is taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (w_stat_evt) begin
            if (r_resp_hit) begin
                if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
            end else begin
                if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lobster_hash_cache.sv
// Self-checking bench for lobster_hash_cache: directed scenarios plus random
// traffic compared against a transaction-level model of the cache.
module tb_lobster_hash_cache;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IB = 8;
    localparam int NE = 1 << IB;
    localparam int BOUND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    lobster_hash_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef LOBSTER_HASH_CACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    lobster_hash_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(IB)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef LOBSTER_HASH_CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    bit          mv [NE];
    logic [AW-1:0] mt [NE];
    logic [DW-1:0] md [NE];

    function automatic int hidx(input logic [AW-1:0] a);
        logic [63:0] a64;
        logic [31:0] f, h1, h2, h;
        a64 = 64'(a);
        f   = a64[31:0] ^ a64[63:32];
        h1  = ((f >> 16) ^ f) * 32'h045d9f3b;
        h2  = ((h1 >> 16) ^ h1) * 32'h045d9f3b;
        h   = (h2 >> 16) ^ h2;
        return int'(h % 32'(NE));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) mv[i] = 1'b0;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic h, output logic [DW-1:0] r, output int lat);
        int  i;
        bit  found;
        i   = hidx(a);
        lat = 3;
        case (op)
            2'b00: begin
                h = mv[i] && (mt[i] == a);
                r = h ? md[i] : '0;
            end
            2'b01: begin
                h = mv[i] && (mt[i] == a);
                r = mv[i] ? md[i] : '0;
                mv[i] = 1'b1; mt[i] = a; md[i] = d;
            end
            2'b11: begin
                h = mv[i] && (mt[i] == a);
                r = '0;
                if (h) mv[i] = 1'b0;
            end
            default: begin
                found = 1'b0;
                h = 1'b0; r = 32'h8000_0000; lat = NE + 1;
                for (int k = 0; k < NE; k++) begin
                    if (!found && mv[k] && (md[k] == d)) begin
                        found = 1'b1; h = 1'b1; r = DW'(k); lat = k + 2;
                    end
                end
            end
        endcase
    endtask

    // Presents one request, waits for acceptance and for the response; leaves it pending.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic h, output logic [DW-1:0] r, output int lat);
        int n;
        h = 1'b0; r = '0; lat = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_data = d;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            nvec++; nerr++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        while (lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid === 1'b1) break;
        end
        if (bus.resp_valid !== 1'b1) begin
            nvec++; nerr++;
            $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", bus.resp_valid, lat);
        end
        h = bus.resp_hit;
        r = bus.resp_data;
    endtask

    task automatic take();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic wait_init(output int cnt, output int busy_bad);
        cnt = 0; busy_bad = 0;
        while (bus.req_ready !== 1'b1 && cnt < BOUND) begin
            if (busy !== 1'b1) busy_bad++;
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cnt, bb;
        logic h; logic [DW-1:0] r; int lat;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_data = '0;
        bus.resp_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({bus.req_ready, bus.resp_valid, busy, bus.resp_hit} !== 4'b0010 || bus.resp_data !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: rdy=%b rv=%b busy=%b hit=%b data=%h, required 0 0 1 0 0",
                     bus.req_ready, bus.resp_valid, busy, bus.resp_hit, bus.resp_data);
        end
        rst = 1'b1;
        wait_init(cnt, bb);
        model_clear();
        nvec++;
        if (cnt !== NE) begin nerr++; $display("FAIL init_length: got %0d cycles, required %0d", cnt, NE); end
        nvec++;
        if (bb !== 0) begin nerr++; $display("FAIL init_busy: busy low in %0d INIT cycles, required 0", bb); end
        issue(2'b00, 32'h0, '0, h, r, lat); take();
        nvec++;
        if (h !== 1'b0 || r !== '0 || lat !== 3) begin
            nerr++;
            $display("FAIL init_read: hit=%b data=%h lat=%0d, required 0 0 3", h, r, lat);
        end
    endtask

    task automatic test_write_read();
        logic h, eh; logic [DW-1:0] r, er; int lat, el;
        issue(2'b01, 32'hFFF80000, 32'h12345678, h, r, lat); take();
        model_op(2'b01, 32'hFFF80000, 32'h12345678, eh, er, el);
        nvec++;
        if (h !== 1'b0 || h !== eh || r !== er || lat !== 3) begin
            nerr++;
            $display("FAIL write_new: hit=%b data=%h lat=%0d, required %b %h 3", h, r, lat, eh, er);
        end
        issue(2'b00, 32'hFFF80000, '0, h, r, lat); take();
        model_op(2'b00, 32'hFFF80000, '0, eh, er, el);
        nvec++;
        if (h !== 1'b1 || r !== 32'h12345678 || lat !== 3) begin
            nerr++;
            $display("FAIL read_hit: hit=%b data=%h lat=%0d, required 1 12345678 3", h, r, lat);
        end
    endtask

    task automatic test_collision();
        logic h, eh; logic [DW-1:0] r, er; int lat, el;
        logic [AW-1:0] b;
        b = 32'h1;
        while (hidx(b) != hidx(32'hFFF80000) || b == 32'hFFF80000) b = b + 1;
        issue(2'b01, b, 32'hCAFEBABE, h, r, lat); take();
        model_op(2'b01, b, 32'hCAFEBABE, eh, er, el);
        nvec++;
        if (h !== 1'b0 || r !== 32'h12345678) begin
            nerr++;
            $display("FAIL evict_write: hit=%b data=%h, required 0 12345678", h, r);
        end
        issue(2'b00, 32'hFFF80000, '0, h, r, lat); take();
        model_op(2'b00, 32'hFFF80000, '0, eh, er, el);
        nvec++;
        if (h !== 1'b0 || r !== '0) begin
            nerr++;
            $display("FAIL evicted_read: hit=%b data=%h, required 0 0", h, r);
        end
        issue(2'b11, b, '0, h, r, lat); take();
        model_op(2'b11, b, '0, eh, er, el);
        nvec++;
        if (h !== 1'b1 || r !== '0 || lat !== 3) begin
            nerr++;
            $display("FAIL invalidate: hit=%b data=%h lat=%0d, required 1 0 3", h, r, lat);
        end
        issue(2'b00, b, '0, h, r, lat); take();
        model_op(2'b00, b, '0, eh, er, el);
        nvec++;
        if (h !== 1'b0) begin nerr++; $display("FAIL read_after_inv: hit=%b, required 0", h); end
    endtask

    task automatic test_find();
        logic h, eh; logic [DW-1:0] r, er; int lat, el, k;
        k = hidx(32'h00001234);
        issue(2'b01, 32'h00001234, 32'hDEADBEEF, h, r, lat); take();
        model_op(2'b01, 32'h00001234, 32'hDEADBEEF, eh, er, el);
        issue(2'b10, '0, 32'hDEADBEEF, h, r, lat); take();
        model_op(2'b10, '0, 32'hDEADBEEF, eh, er, el);
        nvec++;
        if (h !== 1'b1 || r !== DW'(k) || lat !== k + 2) begin
            nerr++;
            $display("FAIL find_hit: hit=%b data=%h lat=%0d, required 1 %h %0d", h, r, lat, DW'(k), k + 2);
        end
        issue(2'b10, '0, 32'h0BADF00D, h, r, lat); take();
        model_op(2'b10, '0, 32'h0BADF00D, eh, er, el);
        nvec++;
        if (h !== 1'b0 || r !== 32'h80000000 || lat !== NE + 1) begin
            nerr++;
            $display("FAIL find_miss: hit=%b data=%h lat=%0d, required 0 80000000 %0d", h, r, lat, NE + 1);
        end
    endtask

    task automatic test_backpressure();
        logic h, eh; logic [DW-1:0] r, er; int lat, el;
        issue(2'b00, 32'h00001234, '0, h, r, lat);
        model_op(2'b00, 32'h00001234, '0, eh, er, el);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            nvec++;
            if (bus.resp_valid !== 1'b1 || bus.resp_hit !== eh || bus.resp_data !== er || bus.req_ready !== 1'b0) begin
                nerr++;
                $display("FAIL hold_resp c%0d: rv=%b hit=%b data=%h rdy=%b, required 1 %b %h 0",
                         c, bus.resp_valid, bus.resp_hit, bus.resp_data, bus.req_ready, eh, er);
            end
        end
        take();
    endtask

    task automatic test_back_to_back();
        logic h, eh; logic [DW-1:0] r, er; int lat, el;
        issue(2'b00, 32'h00001234, '0, h, r, lat);
        model_op(2'b00, 32'h00001234, '0, eh, er, el);
        take();
        @(negedge clk);
        nvec++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL after_take: rv=%b rdy=%b, required 0 1", bus.resp_valid, bus.req_ready);
        end
        issue(2'b00, 32'h00001234, '0, h, r, lat); take();
        nvec++;
        if (h !== eh || r !== er || lat !== 3) begin
            nerr++;
            $display("FAIL b2b_read: hit=%b data=%h lat=%0d, required %b %h 3", h, r, lat, eh, er);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n, cnt, bb;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_data = 32'h0BADF00D;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (20) @(negedge clk);
        nvec++;
        if (busy !== 1'b1 || bus.resp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL scanning: busy=%b rv=%b, required 1 0", busy, bus.resp_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL reset_mid_scan: rv=%b rdy=%b busy=%b, required 0 0 1", bus.resp_valid, bus.req_ready, busy);
        end
        rst = 1'b1;
        wait_init(cnt, bb);
        model_clear();
        nvec++;
        if (cnt !== NE || bb !== 0) begin
            nerr++;
            $display("FAIL reinit_length: got %0d cycles busy_bad=%0d, required %0d 0", cnt, bb, NE);
        end
    endtask

    task automatic test_random();
        logic h, eh; logic [DW-1:0] r, er; int lat, el;
        logic [AW-1:0] apool [8];
        logic [DW-1:0] dpool [4];
        logic [1:0] op; logic [AW-1:0] a; logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) apool[i] = $urandom;
        apool[7] = apool[6] + 1;
        for (int i = 0; i < 4; i++) dpool[i] = $urandom;
        for (int t = 0; t < 80; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = apool[$urandom_range(0, 7)];
            d  = dpool[$urandom_range(0, 3)];
            issue(op, a, d, h, r, lat); take();
            model_op(op, a, d, eh, er, el);
            nvec++;
            if (h !== eh || r !== er || lat !== el) begin
                nerr++;
                $display("FAIL random t%0d op%0d a=%h d=%h: hit=%b data=%h lat=%0d, required %b %h %0d",
                         t, op, a, d, h, r, lat, eh, er, el);
            end
        end
    endtask

`ifdef LOBSTER_HASH_CACHE_STATS_EN
    task automatic test_stats();
        logic h, eh; logic [DW-1:0] r, er; int lat, el;
        logic [31:0] h0, m0;
        int eh_cnt, em_cnt;
        logic [AW-1:0] a;
        @(negedge clk);
        h0 = stat_hits; m0 = stat_misses;
        eh_cnt = 0; em_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            a = 32'h5000 + 32'(i) * 32'h1111;
            issue(2'b01, a, 32'(i), h, r, lat); take();
            model_op(2'b01, a, 32'(i), eh, er, el);
        end
        issue(2'b11, 32'h7777777, '0, h, r, lat); take();
        model_op(2'b11, 32'h7777777, '0, eh, er, el);
        @(negedge clk);
        nvec++;
        if (stat_hits !== h0 || stat_misses !== m0) begin
            nerr++;
            $display("FAIL stats_wr_inv: hits=%0d misses=%0d, required %0d %0d", stat_hits, stat_misses, h0, m0);
        end
        for (int i = 0; i < 5; i++) begin
            a = (i < 3) ? 32'h5000 + 32'(i) * 32'h1111 : 32'h9000_0000 + 32'(i);
            issue(2'b00, a, '0, h, r, lat); take();
            model_op(2'b00, a, '0, eh, er, el);
            if (eh) eh_cnt++; else em_cnt++;
        end
        @(negedge clk);
        nvec++;
        if (stat_hits !== h0 + 32'(eh_cnt) || stat_misses !== m0 + 32'(em_cnt)) begin
            nerr++;
            $display("FAIL stats_reads: hits=%0d misses=%0d, required %0d %0d",
                     stat_hits, stat_misses, h0 + 32'(eh_cnt), m0 + 32'(em_cnt));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_find();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef LOBSTER_HASH_CACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_scan();
        test_write_read();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
